// File: rtl/misao_mem_arbiter.sv
// rtl/misao_mem_arbiter.sv - two-port arbiter/sequencer for the byte-wide single-port program/data SRAM
// Splits 1- or 2-byte little-endian accesses into byte beats and returns a one-cycle ack.
module misao_mem_arbiter #(
   parameter int ADDR_W     = 15,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic              p0_len,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [15:0]       p0_wdata,
   output logic              p0_ack,
   output logic [15:0]       p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic              p1_len,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [15:0]       p1_wdata,
   output logic              p1_ack,
   output logic [15:0]       p1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_enable_read,
   output logic              mem_enable_write,
   output logic              mem_rw,
   output logic [7:0]        mem_data_out,
   input  logic [7:0]        mem_data_in,
   output logic              busy,
   output logic              grant_id
);

   typedef enum logic [1:0] {IDLE, BEAT, CAPT, RESP} state_t;

   state_t            state;
   logic              beat;
   logic              last_grant;
   logic              lat_we;
   logic              lat_len;
   logic [ADDR_W-1:0] lat_addr;
   logic [7:0]        lat_whi;
   logic [15:0]       rdata_buf;

   logic              win;
   logic              sel_we;
   logic              sel_len;
   logic [ADDR_W-1:0] sel_addr;
   logic [15:0]       sel_wdata;
   logic [15:0]       capt_buf;

   // Winner of IDLE arbitration: a lone requester wins; on a tie either port 0 or the port not served last
   always_comb begin
      win = 1'b0;
      if (p0_req && p1_req)
         win = FIXED_PRIO ? 1'b0 : ~last_grant;
      else
         win = p1_req;
   end

   assign sel_we    = win ? p1_we    : p0_we;
   assign sel_len   = win ? p1_len   : p0_len;
   assign sel_addr  = win ? p1_addr  : p0_addr;
   assign sel_wdata = win ? p1_wdata : p0_wdata;

   // Read buffer with the current beat's byte merged in, so RESP can present it the same edge it is captured
   always_comb begin
      capt_buf = rdata_buf;
      if (!lat_we) begin
         if (beat)
            capt_buf[15:8] = mem_data_in;
         else
            capt_buf[7:0] = mem_data_in;
      end
   end

   // Transaction FSM; every output is registered and set on the transition into the state that shows it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         beat             <= 1'b0;
         last_grant       <= 1'b1;
         lat_we           <= 1'b0;
         lat_len          <= 1'b0;
         lat_addr         <= '0;
         lat_whi          <= 8'h00;
         rdata_buf        <= 16'h0000;
         p0_ack           <= 1'b0;
         p1_ack           <= 1'b0;
         p0_rdata         <= 16'h0000;
         p1_rdata         <= 16'h0000;
         mem_addr         <= '0;
         mem_enable_read  <= 1'b0;
         mem_enable_write <= 1'b0;
         mem_rw           <= 1'b1;
         mem_data_out     <= 8'h00;
         busy             <= 1'b0;
         grant_id         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (p0_req || p1_req) begin
                  grant_id         <= win;
                  lat_we           <= sel_we;
                  lat_len          <= sel_len;
                  lat_addr         <= sel_addr;
                  lat_whi          <= sel_wdata[15:8];
                  beat             <= 1'b0;
                  rdata_buf        <= 16'h0000;
                  mem_addr         <= sel_addr;
                  mem_enable_read  <= ~sel_we;
                  mem_enable_write <= sel_we;
                  mem_rw           <= ~sel_we;
                  if (sel_we)
                     mem_data_out <= sel_wdata[7:0];
                  busy             <= 1'b1;
                  state            <= BEAT;
               end
            end
            BEAT: begin
               mem_enable_read  <= 1'b0;
               mem_enable_write <= 1'b0;
               mem_rw           <= 1'b1;
               state            <= CAPT;
            end
            CAPT: begin
               rdata_buf <= capt_buf;
               if (beat == lat_len) begin
                  if (grant_id) begin
                     p1_ack   <= 1'b1;
                     p1_rdata <= capt_buf;
                  end else begin
                     p0_ack   <= 1'b1;
                     p0_rdata <= capt_buf;
                  end
                  state <= RESP;
               end else begin
                  // Second beat; the add truncates so the address wraps to 0 at the top of memory
                  beat             <= 1'b1;
                  mem_addr         <= lat_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                  mem_enable_read  <= ~lat_we;
                  mem_enable_write <= lat_we;
                  mem_rw           <= ~lat_we;
                  if (lat_we)
                     mem_data_out <= lat_whi;
                  state            <= BEAT;
               end
            end
            RESP: begin
               p0_ack     <= 1'b0;
               p1_ack     <= 1'b0;
               last_grant <= grant_id;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_misao_mem_arbiter.sv
// tb/tb_misao_mem_arbiter.sv - self-checking bench for misao_mem_arbiter (round-robin and fixed-priority builds)
module tb_misao_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p0_req = 1'b0, p0_we = 1'b0, p0_len = 1'b0;
   logic [14:0] p0_addr = '0;
   logic [15:0] p0_wdata = '0;
   logic        p1_req = 1'b0, p1_we = 1'b0, p1_len = 1'b0;
   logic [14:0] p1_addr = '0;
   logic [15:0] p1_wdata = '0;

   logic        a_p0_ack, a_p1_ack, a_rd, a_wr, a_rw, a_busy, a_gid;
   logic [15:0] a_p0_rdata, a_p1_rdata;
   logic [14:0] a_mem_addr;
   logic [7:0]  a_dout;
   logic [7:0]  a_din = 8'h00;

   logic        b_p0_ack, b_p1_ack, b_rd, b_wr, b_rw, b_busy, b_gid;
   logic [15:0] b_p0_rdata, b_p1_rdata;
   logic [14:0] b_mem_addr;
   logic [7:0]  b_dout;
   logic [7:0]  b_din = 8'h00;

   logic        pl_en = 1'b0;
   logic [14:0] pl_addr = '0;
   logic [7:0]  pl_data = '0;

   logic [7:0]  mem_a [0:32767];
   logic [7:0]  mem_b [0:32767];
   logic [7:0]  ref_mem [0:32767];

   int errors = 0;
   int checks = 0;
   bit last_served = 1'b1;

   always #5 clk = ~clk;

   misao_mem_arbiter #(.ADDR_W(15), .FIXED_PRIO(1'b0)) dut_rr (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_len(p0_len), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_len(p1_len), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
      .mem_addr(a_mem_addr), .mem_enable_read(a_rd), .mem_enable_write(a_wr), .mem_rw(a_rw),
      .mem_data_out(a_dout), .mem_data_in(a_din), .busy(a_busy), .grant_id(a_gid));

   misao_mem_arbiter #(.ADDR_W(15), .FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_len(p0_len), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_len(p1_len), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
      .mem_addr(b_mem_addr), .mem_enable_read(b_rd), .mem_enable_write(b_wr), .mem_rw(b_rw),
      .mem_data_out(b_dout), .mem_data_in(b_din), .busy(b_busy), .grant_id(b_gid));

   // Synchronous SRAM models: read data appears the cycle after the strobe
   always @(posedge clk) begin
      if (pl_en) mem_a[pl_addr] <= pl_data;
      else if (a_wr) mem_a[a_mem_addr] <= a_dout;
      if (a_rd) a_din <= mem_a[a_mem_addr];
   end

   always @(posedge clk) begin
      if (b_wr) mem_b[b_mem_addr] <= b_dout;
      if (b_rd) b_din <= mem_b[b_mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [14:0] addr, input logic [7:0] data);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = addr; pl_data = data;
      ref_mem[addr] = data;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // One transaction on the round-robin DUT, checked against the reference memory and latency rule
   task automatic txn(input bit port, input bit we, input bit len, input logic [14:0] addr,
                      input logic [15:0] wdata, output logic [15:0] rdata);
      int n, nb;
      logic [14:0] ba [2];
      logic [14:0] a1;
      logic ackp, acko;
      logic [15:0] exp_rd;
      a1 = addr + 15'd1;
      @(negedge clk);
      if (port) begin
         p1_req = 1'b1; p1_we = we; p1_len = len; p1_addr = addr; p1_wdata = wdata;
      end else begin
         p0_req = 1'b1; p0_we = we; p0_len = len; p0_addr = addr; p0_wdata = wdata;
      end
      n = 0; nb = 0; ackp = 1'b0; acko = 1'b0; ba[0] = '0; ba[1] = '0;
      while (!ackp && n < 20) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (a_rd || a_wr) begin
            if (nb < 2) ba[nb] = a_mem_addr;
            nb++;
         end
         ackp = port ? a_p1_ack : a_p0_ack;
         acko = acko | (port ? a_p0_ack : a_p1_ack);
      end
      rdata = port ? a_p1_rdata : a_p0_rdata;
      p0_req = 1'b0; p1_req = 1'b0;
      check("ack_latency", n, len ? 5 : 3);
      check("beat_count", nb, len ? 2 : 1);
      check("beat0_addr", {17'd0, ba[0]}, {17'd0, addr});
      if (len) check("beat1_addr", {17'd0, ba[1]}, {17'd0, a1});
      check("other_ack", {31'd0, acko}, 32'd0);
      if (we) begin
         ref_mem[addr] = wdata[7:0];
         if (len) ref_mem[a1] = wdata[15:8];
      end else begin
         exp_rd = {len ? ref_mem[a1] : 8'h00, ref_mem[addr]};
         check("rdata", {16'd0, rdata}, {16'd0, exp_rd});
      end
      last_served = port;
      @(posedge clk);
      @(negedge clk);
      check("ack_one_cycle", {30'd0, a_p0_ack, a_p1_ack}, 32'd0);
      check("idle_busy", {31'd0, a_busy}, 32'd0);
   endtask

   initial begin
      logic [15:0] rd;
      int n, got;
      bit exp_port, seen_p1, rst_ack;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_acks", {30'd0, a_p0_ack, a_p1_ack}, 32'd0);
      check("rst_rdata", {a_p0_rdata, a_p1_rdata}, 32'd0);
      check("rst_strobes", {29'd0, a_rd, a_wr, a_rw}, 32'd1);
      check("rst_addr_dout", {9'd0, a_mem_addr, a_dout}, 32'd0);
      check("rst_busy_gid", {30'd0, a_busy, a_gid}, 32'd0);

      for (int i = 0; i < 32; i++) preload(15'h7FF0 + 15'(i), 8'($urandom));
      rst = 1'b0;
      preload(15'h0010, 8'hA5);
      preload(15'h7FFF, 8'h12);
      preload(15'h0000, 8'h34);

      // Single read
      txn(1'b0, 1'b0, 1'b0, 15'h0010, 16'h0000, rd);
      check("single_read", {16'd0, rd}, 32'h00A5);

      // 16-bit write then read on port 1
      txn(1'b1, 1'b1, 1'b1, 15'h0200, 16'hBEEF, rd);
      check("wr_lo_byte", {24'd0, mem_a[15'h0200]}, 32'hEF);
      check("wr_hi_byte", {24'd0, mem_a[15'h0201]}, 32'hBE);
      txn(1'b1, 1'b0, 1'b1, 15'h0200, 16'h0000, rd);
      check("rd16", {16'd0, rd}, 32'hBEEF);
      check("p0_rdata_hold", {16'd0, a_p0_rdata}, 32'h00A5);

      // Wrap at the top of memory
      txn(1'b0, 1'b0, 1'b1, 15'h7FFF, 16'h0000, rd);
      check("wrap_read", {16'd0, rd}, 32'h3412);

      // Randomized accesses around the wrap region
      for (int i = 0; i < 24; i++) begin
         txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             15'h7FF0 + 15'($urandom_range(0, 30)), 16'($urandom), rd);
      end

      // Round-robin with both ports requesting continuously
      txn(1'b1, 1'b0, 1'b0, 15'h0010, 16'h0000, rd);
      exp_port = ~last_served;
      @(negedge clk);
      p0_req = 1'b1; p0_we = 1'b0; p0_len = 1'b0; p0_addr = 15'h0010;
      p1_req = 1'b1; p1_we = 1'b0; p1_len = 1'b0; p1_addr = 15'h0200;
      got = 0; n = 0;
      while (got < 4 && n < 60) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (a_p0_ack || a_p1_ack) begin
            check("rr_overlap", {31'd0, a_p0_ack & a_p1_ack}, 32'd0);
            check("rr_order", {31'd0, a_p1_ack}, {31'd0, exp_port});
            exp_port = ~exp_port;
            got++;
         end
      end
      check("rr_ack_count", got, 4);
      check("rr_p0_data", {a_p0_rdata, a_p1_rdata}, {16'h00A5, 8'h00, ref_mem[15'h0200]});
      p0_req = 1'b0; p1_req = 1'b0;
      repeat (10) @(negedge clk);

      // Fixed priority: port 0 keeps winning until it drops its request
      p0_req = 1'b1; p1_req = 1'b1;
      got = 0; n = 0; seen_p1 = 1'b0;
      while (got < 3 && n < 60) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (b_p1_ack) seen_p1 = 1'b1;
         if (b_p0_ack) got++;
      end
      p0_req = 1'b0;
      check("fp_p0_served", got, 3);
      check("fp_p1_starved", {31'd0, seen_p1}, 32'd0);
      n = 0;
      while (!b_p1_ack && n < 20) begin
         @(posedge clk); n++;
         @(negedge clk);
      end
      p1_req = 1'b0;
      check("fp_p1_after_drop", {31'd0, b_p1_ack}, 32'd1);
      repeat (10) @(negedge clk);

      // Reset during the first beat of a 2-byte read on port 1
      p1_req = 1'b1; p1_we = 1'b0; p1_len = 1'b1; p1_addr = 15'h7FF5;
      @(posedge clk);
      @(negedge clk);
      check("pre_rst_beat", {30'd0, a_rd, a_gid}, 32'd3);
      rst = 1'b1;
      #1;
      check("rst_mid_strobes", {29'd0, a_rd, a_wr, a_rw}, 32'd1);
      check("rst_mid_busy_gid", {30'd0, a_busy, a_gid}, 32'd0);
      p1_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      rst_ack = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         rst_ack = rst_ack | a_p0_ack | a_p1_ack;
      end
      check("rst_no_ack", {31'd0, rst_ack}, 32'd0);
      txn(1'b1, 1'b0, 1'b1, 15'h7FF5, 16'h0000, rd);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
